// File: rtl/cv32e40s_rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40s_rvfi_pkg
// Brief    : Shared types and constants for RVFI OBI request/response pairing.
// Revision : 1.0
// ============================================================================
package cv32e40s_rvfi_pkg;

    localparam int OBI_PAIR_MAX_DEPTH = 8;
    localparam int OBI_INSTR_REQ_W    = 64;
    localparam int OBI_INSTR_RESP_W   = 34;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } rvfi_obi_pair_err_t;

    // Instruction-side trace record: request payload above response payload.
    typedef struct packed {
        logic [OBI_INSTR_REQ_W-1:0]  req;
        logic [OBI_INSTR_RESP_W-1:0] resp;
    } obi_instr_trace_t;

    function automatic obi_instr_trace_t pack_instr_trace(
        input logic [OBI_INSTR_REQ_W+OBI_INSTR_RESP_W-1:0] pair
    );
        return obi_instr_trace_t'(pair);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40s_rvfi_obi_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40s_rvfi_obi_fifo
// Brief    : Generic DEPTH x WIDTH FIFO with push/pop/flush and occupancy count.
// Revision : 1.0
// ============================================================================
module cv32e40s_rvfi_obi_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (pop && !push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cv32e40s_rvfi_obi_pairer.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40s_rvfi_obi_pairer
// Brief    : Pairs in-order OBI responses with their granted requests for RVFI.
// Revision : 1.0
// ============================================================================
module cv32e40s_rvfi_obi_pairer
    import cv32e40s_rvfi_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int REQ_W  = 64,
    parameter int RESP_W = 34
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         obi_req_i,
    input  logic                         obi_gnt_i,
    input  logic [REQ_W-1:0]             obi_req_payload_i,
    input  logic                         obi_rvalid_i,
    input  logic [RESP_W-1:0]            obi_resp_payload_i,
    input  logic                         flush_i,
    output logic                         pair_valid_o,
    output logic [REQ_W+RESP_W-1:0]      pair_o,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_overflow;
    logic               w_underflow;
    logic [REQ_W-1:0]   w_head;
    logic [c_CNT_W-1:0] w_count;

    logic                     r_pair_valid;
    logic [REQ_W+RESP_W-1:0]  r_pair;
    rvfi_obi_pair_err_t       r_err;

    // A response can never target a request granted in the same cycle, so
    // rvalid on an empty FIFO is an underflow even if a push is in progress.
    assign w_push_req  = obi_req_i & obi_gnt_i;
    assign w_pop       = obi_rvalid_i & ~w_empty;
    assign w_underflow = obi_rvalid_i & w_empty;
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_overflow  = w_push_req & w_full & ~w_pop;

    cv32e40s_rvfi_obi_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (flush_i),
        .wdata (obi_req_payload_i),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_valid <= 1'b0;
            r_pair       <= '0;
            r_err        <= '0;
        end else begin
            r_pair_valid    <= w_pop & ~flush_i;
            if (w_pop && !flush_i) begin
                r_pair <= {w_head, obi_resp_payload_i};
            end
            r_err.overflow  <= r_err.overflow  | w_overflow;
            r_err.underflow <= r_err.underflow | w_underflow;
        end
    end

    assign pair_valid_o  = r_pair_valid;
    assign pair_o        = r_pair;
    assign outstanding_o = w_count;
    assign overflow_o    = r_err.overflow;
    assign underflow_o   = r_err.underflow;

endmodule
`default_nettype wire

// File: doc/cv32e40s_rvfi_obi_pairer.md
CV32E40S_RVFI_OBI_PAIRER -- requirements
Module: cv32e40s_rvfi_obi_pairer

Interface
REQ-001 Parameter DEPTH, default 2: maximum outstanding OBI transactions tracked; legal range 1..8.
REQ-002 Parameter REQ_W, default 64: width of the OBI request payload.
REQ-003 Parameter RESP_W, default 34: width of the OBI response payload.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port obi_req_i, input, 1: OBI address-phase request.
REQ-007 Port obi_gnt_i, input, 1: OBI address-phase grant.
REQ-008 Port obi_req_payload_i, input, REQ_W: request payload, sampled on handshake.
REQ-009 Port obi_rvalid_i, input, 1: OBI response-phase valid.
REQ-010 Port obi_resp_payload_i, input, RESP_W: response payload, sampled with rvalid.
REQ-011 Port flush_i, input, 1: synchronous clear of all tracked transactions.
REQ-012 Port pair_valid_o, output, 1: one-cycle pulse; pair_o is valid.
REQ-013 Port pair_o, output, REQ_W+RESP_W: {request payload, response payload}; the request is in the MSBs.
REQ-014 Port outstanding_o, output, $clog2(DEPTH+1): current FIFO occupancy.
REQ-015 Port overflow_o, output, 1: sticky flag; a granted request was dropped because the FIFO was full.
REQ-016 Port underflow_o, output, 1: sticky flag; rvalid arrived with no tracked request.

Function
REQ-017 Push: obi_req_i && obi_gnt_i SHALL write obi_req_payload_i into the FIFO tail.
REQ-018 Pop: obi_rvalid_i SHALL remove the FIFO head and pair it with obi_resp_payload_i.
REQ-019 Responses SHALL be paired with requests in strict in-order (FIFO) order.
REQ-020 Output latency: pair_valid_o/pair_o SHALL be registered and assert exactly 1 cycle after the pop cycle.
REQ-021 pair_o SHALL hold its last value while pair_valid_o=0.
REQ-022 Push and pop in the same cycle with occupancy>0: occupancy unchanged; the pop returns the old head.
REQ-023 Push and pop in the same cycle with occupancy=0: the OBI rule forbids a same-cycle response, so this SHALL be treated as an underflow; the push is still accepted, occupancy becomes 1, and no pair is emitted.
REQ-024 Pop with occupancy=0: no pair emitted; underflow_o set.
REQ-025 Push with occupancy=DEPTH and no pop: request dropped; overflow_o set; occupancy stays DEPTH.
REQ-026 Push with occupancy=DEPTH and a simultaneous pop: both are legal; no overflow.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH, and the design SHALL be correct for DEPTH values that are not a power of two.
REQ-028 flush_i SHALL clear occupancy and pointers next cycle, with priority over push/pop in that cycle.
REQ-029 flush_i SHALL NOT clear the sticky flags, and SHALL NOT suppress a pair_valid_o already registered.
REQ-030 overflow_o and underflow_o SHALL clear only on reset.
REQ-031 outstanding_o SHALL be registered and equal the occupancy after the current cycle's updates are applied.

Reset
REQ-032 While rst_n=0: pair_valid_o=0, pair_o=0, outstanding_o=0, overflow_o=0, underflow_o=0, and pointers=0.
REQ-033 Asserting reset mid-transaction SHALL discard all tracked entries; after release, the first rvalid SHALL cause an underflow.
REQ-034 FIFO storage MAY be left unreset; its contents SHALL NOT be observable while empty.

Structure
REQ-035 rvfi_obi_pair_err_t (overflow, underflow) and the OBI_PAIR_MAX_DEPTH=8 constant SHALL live in cv32e40s_rvfi_pkg.
REQ-036 Instruction-side use SHALL pack pair_o into the package's existing instruction req/resp trace struct.
REQ-037 A single sub-module, cv32e40s_rvfi_obi_fifo (generic DEPTH x WIDTH, with push/pop/flush/count), SHALL hold the storage.

Verification
REQ-038 DEPTH=2: push A, push B, rvalid r1, rvalid r2 -> pairs {A,r1} then {B,r2}, each one cycle after its rvalid; outstanding sequence 1,2,1,0.
REQ-039 DEPTH=2, occupancy 2: push C without rvalid -> overflow_o=1 and outstanding stays 2; later rvalid pairs with A, not C.
REQ-040 DEPTH=2, occupancy 2: push C with rvalid in the same cycle -> pair {A,r}, outstanding stays 2, overflow_o=0.
REQ-041 Empty FIFO, push D with rvalid in the same cycle -> underflow_o=1, no pair, outstanding=1; next rvalid pairs {D,r}.
REQ-042 DEPTH=3: 7 push/pop round-trips -> pointer wrap; all pairs in order with payloads intact.
REQ-043 Occupancy 2, then flush_i or rst_n pulse -> outstanding=0; a later rvalid gives underflow_o=1 (rst_n also clears the earlier flags first).
